// File: rtl/serial_sub_ctrl_if.sv
// Operand/result bundle for serial_sub_ctrl; carries the `ovf` flag only when
// SUB_OVF_EN is defined.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, bin,
`ifdef SUB_OVF_EN
    input  ovf,
`endif
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
`ifdef SUB_OVF_EN
    output ovf,
`endif
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock through a single
// full-subtractor cell. Optional signed-overflow output enabled by SUB_OVF_EN.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_sub_ctrl_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             c;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             accept;
  logic             last;
  logic             d;
  logic             c_next;
`ifdef SUB_OVF_EN
  logic             ovf_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Full-subtractor cell on the operand LSBs plus the acceptance/last-bit decode.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last       = (state == RUN) && (cnt == CW'(WIDTH - 1));
    d          = x[0] ^ y[0] ^ c;
    c_next     = (~x[0] & y[0]) | (~x[0] & c) | (y[0] & c);
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (last) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x      <= '0;
      y      <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      diff_r <= '0;
      bout_r <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_r  <= 1'b0;
`endif
    end else if (accept) begin
      x   <= bus.a;
      y   <= bus.b;
      c   <= bus.bin;
      cnt <= '0;
    end else if (state == RUN) begin
      x      <= x >> 1;
      y      <= y >> 1;
      c      <= c_next;
      cnt    <= cnt + 1'b1;
      diff_r <= {d, diff_r[WIDTH-1:1]};
      if (last) begin
        bout_r <= c_next;
`ifdef SUB_OVF_EN
        // Borrow into the MSB differs from borrow out: signed result wrapped.
        ovf_r  <= c ^ c_next;
`endif
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_r;
  assign bus.bout = bout_r;
`ifdef SUB_OVF_EN
  assign bus.ovf  = ovf_r;
`endif

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial multi-bit subtractor controller. Computes `a - b - bin` over WIDTH bits, one bit per clock, through a single 1-bit full-subtractor cell that it sequences.
- Captures the operands on a start handshake, shifts them LSB-first through the cell, and carries the borrow in a register between bits.
- Presents the difference, the final borrow and a one-cycle done pulse.
- Low-area alternative to a parallel ripple subtractor in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      synchronous reset, active-high
- start  input   1      request to begin a subtraction; accepted only when busy=0
- a      input   WIDTH  minuend, sampled on the accepting edge
- b      input   WIDTH  subtrahend, sampled on the accepting edge
- bin    input   1      borrow-in, sampled on the accepting edge
- busy   output  1      high while a subtraction is in progress
- done   output  1      one-cycle pulse; diff/bout valid
- diff   output  WIDTH  difference; held from done until the next start is accepted
- bout   output  1      borrow out of the MSB; held like diff

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on rst; it is checked at every rising edge and takes priority over everything else.
  - Reset values: state=IDLE, busy=0, done=0, diff=0, bout=0, bit counter=0, borrow register=0, operand shift registers=0.
- States: IDLE, RUN, DONE. Encoding is free; no other reachable states.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: latch a, b, bin (borrow register <= bin), counter <= 0, go to RUN.
- RUN:
  - busy=1.
  - Each edge processes bit i = counter using the LSBs of the operand shift registers (x, y) and the borrow register c:
    - d = x ^ y ^ c
    - c_next = (~x & y) | (~x & c) | (y & c)
  - d is shifted into diff from the MSB side, so after WIDTH edges diff[0] holds bit 0.
  - Operand registers shift right, borrow register <= c_next, counter increments.
  - On the edge processing bit WIDTH-1: bout <= c_next, go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Next edge: if start=1, accept a new operation exactly as in IDLE (back-to-back allowed); otherwise go to IDLE.
- Latency:
  - start accepted at edge k → done=1 in the cycle after edge k+WIDTH.
  - Throughput: one result per WIDTH+1 cycles.
- Rules:
  - start while busy=1 is ignored and does not queue.
  - a, b and bin may change freely after acceptance.
  - diff is architecturally valid only while done=1 and afterwards until the next acceptance.
  - During RUN, diff holds a partially shifted value; the bench must not check it.
  - Modulo-2^WIDTH result: diff = (a - b - bin) mod 2^WIDTH; bout=1 iff a < b + bin (unsigned).
- Reset mid-RUN aborts the operation: no done pulse, and all outputs return to their reset values on that edge.
- start=1 and rst=1 on the same edge: reset wins and start is dropped.

Optional Feature:
- Macro: SUB_OVF_EN.
- Defined:
  - Adds output port `ovf` (1 bit), registered, reset 0.
  - Updated on the MSB edge together with bout: ovf = (borrow into bit WIDTH-1) XOR (borrow out of bit WIDTH-1), i.e. signed two's-complement overflow of a - b - bin.
  - ovf is held like bout.
- Not defined:
  - Port `ovf` is absent.
  - Logic and state behaviour are otherwise identical.

Test Plan (WIDTH=8):
- Reset then a=0x05, b=0x03, bin=0, start at edge 0 → busy=1 for cycles 1..8; done=1 after edge 8; diff=0x02, bout=0.
- a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1; a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1; a=0xFF, b=0xFF, bin=1 → diff=0xFF, bout=1.
- start pulsed again at cycle 3 of RUN with a=0x10 → ignored; result is still that of the first operands; exactly one done pulse.
- rst=1 at cycle 4 of RUN → done never asserts; busy=0, diff=0x00, bout=0 next cycle; a new start afterwards produces a correct result.
- start held high through the DONE cycle with new a=0x20, b=0x01 → accepted on that edge; second done exactly 9 cycles after the first with diff=0x1F, bout=0.
- With SUB_OVF_EN: a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1; a=0x7F, b=0x01 → diff=0x7E, ovf=0.
